gp_arbiter: RTL and testbench

//   Shares the single graphics processor (rect fill/outline engine, en/finish handshake) between
//   NUM_REQ painters: game controller, keypad highlighter and score overlay. Round-robin grant,
//   one command at a time. Each requester keeps the same en/finish protocol it would use on the

---
 rtl/gp_arbiter.sv | 163 ++++++++++++++++
 tb/tb_gp_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_arbiter.sv
// gp_arbiter: round-robin share of one rect graphics processor
// between NUM_REQ painters, with screen clamping.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   req_en/req_opcode   per-slot request and opcode
//   req_tl_*/req_br_*   per-slot packed rectangle corners
//   req_arg             per-slot 12-bit BGR colour
//   req_finish          completion to the granted slot
//   grant               one-hot owner, zero when idle
//   gp_en, gp_*         latched command to the processor
//   gp_finish           completion from the processor
module gp_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int MAX_X   = 639,
  parameter int MAX_Y   = 479
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_en,
  input  logic [NUM_REQ-1:0]    req_opcode,
  input  logic [10*NUM_REQ-1:0] req_tl_x,
  input  logic [9*NUM_REQ-1:0]  req_tl_y,
  input  logic [10*NUM_REQ-1:0] req_br_x,
  input  logic [9*NUM_REQ-1:0]  req_br_y,
  input  logic [12*NUM_REQ-1:0] req_arg,
  output logic [NUM_REQ-1:0]    req_finish,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  gp_en,
  output logic                  gp_opcode,
  output logic [9:0]            gp_tl_x,
  output logic [8:0]            gp_tl_y,
  output logic [9:0]            gp_br_x,
  output logic [8:0]            gp_br_y,
  output logic [11:0]           gp_arg,
  input  logic                  gp_finish
);

  localparam int OW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] CLAMP_X = 10'(MAX_X);
  localparam logic [8:0] CLAMP_Y = 9'(MAX_Y);

  typedef enum logic [1:0] {
    IDLE, LATCH, EXEC, DONE
  } state_t;

  state_t state;

  logic [OW-1:0] rr;
  logic [OW-1:0] owner;
  logic [OW-1:0] owner_nxt;
  logic [OW-1:0] pick;
  logic          pick_vld;

  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] own_oh;

  logic       o_op;
  logic [9:0] o_tl_x;
  logic [8:0] o_tl_y;
  logic [9:0] o_br_x;
  logic [8:0] o_br_y;
  logic [11:0] o_arg;
  logic [9:0] c_br_x;
  logic [8:0] c_br_y;
  logic       drop;

  // Scan downward from the last slot so the
  // first set bit at or after rr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_en[(int'(rr) + k) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick = OW'((int'(rr) + k) % NUM_REQ);
      end
    end
  end

  assign pick_oh = NUM_REQ'(1) << pick;
  assign own_oh  = NUM_REQ'(1) << owner;

  assign owner_nxt =
    (owner == OW'(NUM_REQ - 1)) ? '0
                                : owner + 1'b1;

  assign o_op   = req_opcode[owner];
  assign o_tl_x = req_tl_x[owner*10 +: 10];
  assign o_tl_y = req_tl_y[owner*9 +: 9];
  assign o_br_x = req_br_x[owner*10 +: 10];
  assign o_br_y = req_br_y[owner*9 +: 9];
  assign o_arg  = req_arg[owner*12 +: 12];

  assign c_br_x =
    (o_br_x > CLAMP_X) ? CLAMP_X : o_br_x;
  assign c_br_y =
    (o_br_y > CLAMP_Y) ? CLAMP_Y : o_br_y;

  // Empty after clamping: nothing to draw.
  assign drop =
    (o_tl_x > c_br_x) || (o_tl_y > c_br_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= '0;
      owner      <= '0;
      grant      <= '0;
      req_finish <= '0;
      gp_en      <= 1'b0;
      gp_opcode  <= 1'b0;
      gp_tl_x    <= '0;
      gp_tl_y    <= '0;
      gp_br_x    <= '0;
      gp_br_y    <= '0;
      gp_arg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            grant <= pick_oh;
            state <= LATCH;
          end
        end
        LATCH: begin
          gp_opcode <= o_op;
          gp_tl_x   <= o_tl_x;
          gp_tl_y   <= o_tl_y;
          gp_br_x   <= c_br_x;
          gp_br_y   <= c_br_y;
          gp_arg    <= o_arg;
          if (drop) begin
            req_finish <= own_oh;
            state      <= DONE;
          end else begin
            gp_en <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (gp_finish) begin
            gp_en      <= 1'b0;
            req_finish <= own_oh;
            state      <= DONE;
          end
        end
        DONE: begin
          if (!req_en[owner] && !gp_finish) begin
            req_finish <= '0;
            grant      <= '0;
            rr         <= owner_nxt;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gp_arbiter.sv
// tb_gp_arbiter: directed bench for gp_arbiter
// with a small graphics-processor responder.
module tb_gp_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_en;
  logic [N-1:0]  req_opcode;
  logic [10*N-1:0] req_tl_x;
  logic [9*N-1:0]  req_tl_y;
  logic [10*N-1:0] req_br_x;
  logic [9*N-1:0]  req_br_y;
  logic [12*N-1:0] req_arg;
  logic [N-1:0]  req_finish;
  logic [N-1:0]  grant;
  logic          gp_en;
  logic          gp_opcode;
  logic [9:0]    gp_tl_x;
  logic [8:0]    gp_tl_y;
  logic [9:0]    gp_br_x;
  logic [8:0]    gp_br_y;
  logic [11:0]   gp_arg;
  logic          gp_finish;

  int n_chk = 0;
  int n_err = 0;

  int   gp_delay   = 10;
  int   gp_cnt     = 0;
  int   en_cycles  = 0;
  logic gp_done    = 1'b0;

  gp_arbiter #(
    .NUM_REQ(N),
    .MAX_X(639),
    .MAX_Y(479)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_en(req_en),
    .req_opcode(req_opcode),
    .req_tl_x(req_tl_x),
    .req_tl_y(req_tl_y),
    .req_br_x(req_br_x),
    .req_br_y(req_br_y),
    .req_arg(req_arg),
    .req_finish(req_finish),
    .grant(grant),
    .gp_en(gp_en),
    .gp_opcode(gp_opcode),
    .gp_tl_x(gp_tl_x),
    .gp_tl_y(gp_tl_y),
    .gp_br_x(gp_br_x),
    .gp_br_y(gp_br_y),
    .gp_arg(gp_arg),
    .gp_finish(gp_finish)
  );

  always #5 clk = ~clk;

  // Processor: finish gp_delay cycles after gp_en,
  // finish falls as soon as gp_en falls.
  assign gp_finish = gp_en & gp_done;

  always @(posedge clk) begin
    if (gp_en) en_cycles <= en_cycles + 1;
    if (!gp_en) begin
      gp_done <= 1'b0;
      gp_cnt  <= 0;
    end else if (gp_cnt == gp_delay - 1)
      gp_done <= 1'b1;
    else
      gp_cnt <= gp_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic op,
                         int tx, int ty,
                         int bx, int by,
                         logic [11:0] a);
    req_opcode[i]        = op;
    req_tl_x[i*10 +: 10] = 10'(tx);
    req_tl_y[i*9 +: 9]   = 9'(ty);
    req_br_x[i*10 +: 10] = 10'(bx);
    req_br_y[i*9 +: 9]   = 9'(by);
    req_arg[i*12 +: 12]  = a;
  endtask

  task automatic wait_gp_en(string tag);
    for (int k = 0; k < 100 && !gp_en; k++) tick();
    check(tag, 32'(gp_en), 32'd1);
  endtask

  task automatic wait_rf(string tag);
    for (int k = 0; k < 100 && req_finish == '0; k++)
      tick();
    check(tag, 32'(req_finish != '0), 32'd1);
  endtask

  task automatic wait_idle(string tag);
    for (int k = 0; k < 100 && grant != '0; k++)
      tick();
    check(tag, 32'(grant), 32'd0);
  endtask

  task automatic serve(string tag, logic [N-1:0] exp);
    wait_rf({tag, "_rf_to"});
    check({tag, "_grant"}, 32'(grant), 32'(exp));
    check({tag, "_rf"}, 32'(req_finish), 32'(exp));
    req_en = req_en & ~exp;
    wait_idle({tag, "_idle"});
    check({tag, "_rf_clr"}, 32'(req_finish), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int e0;
    rst        = 1'b1;
    req_en     = '0;
    req_opcode = '0;
    req_tl_x   = '0;
    req_tl_y   = '0;
    req_br_x   = '0;
    req_br_y   = '0;
    req_arg    = '0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rf", 32'(req_finish), 32'd0);
    check("rst_gp_en", 32'(gp_en), 32'd0);
    check("rst_br_x", 32'(gp_br_x), 32'd0);
    check("rst_arg", 32'(gp_arg), 32'd0);

    // 1: single fill, latency
    set_req(0, 1'b0, 0, 0, 639, 479, 12'hABC);
    req_en = 3'b001;
    tick();
    check("t1_grant_p1", 32'(grant), 32'd1);
    check("t1_en_p1", 32'(gp_en), 32'd0);
    tick();
    check("t1_en_p2", 32'(gp_en), 32'd1);
    check("t1_br_x", 32'(gp_br_x), 32'd639);
    check("t1_br_y", 32'(gp_br_y), 32'd479);
    check("t1_arg", 32'(gp_arg), 32'hABC);
    for (k = 1; k <= 50; k++) begin
      tick();
      if (gp_finish) break;
    end
    check("t1_fin_lat", 32'(k), 32'd10);
    check("t1_grant_x", 32'(grant), 32'd1);
    tick();
    check("t1_rf", 32'(req_finish), 32'd1);
    check("t1_en_off", 32'(gp_en), 32'd0);
    check("t1_grant_d", 32'(grant), 32'd1);
    req_en = '0;
    tick();
    check("t1_idle", 32'(grant), 32'd0);
    check("t1_rf_clr", 32'(req_finish), 32'd0);

    // 2: simultaneous requests, round robin
    do_reset();
    gp_delay = 3;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b0, 0, 0, 639, 479, 12'h111);
    req_en = 3'b111;
    serve("t2a", 3'b001);
    serve("t2b", 3'b010);
    serve("t2c", 3'b100);
    req_en = 3'b011;
    serve("t2d", 3'b001);
    serve("t2e", 3'b010);

    // 3: clamping
    set_req(1, 1'b1, 600, 400, 700, 500, 12'h123);
    req_en = 3'b010;
    wait_gp_en("t3_en");
    check("t3_grant", 32'(grant), 32'd2);
    check("t3_tl_x", 32'(gp_tl_x), 32'd600);
    check("t3_tl_y", 32'(gp_tl_y), 32'd400);
    check("t3_br_x", 32'(gp_br_x), 32'd639);
    check("t3_br_y", 32'(gp_br_y), 32'd479);
    check("t3_op", 32'(gp_opcode), 32'd1);
    serve("t3", 3'b010);

    // 4: degenerate after clamp is dropped
    set_req(2, 1'b0, 640, 10, 700, 20, 12'h0F0);
    e0 = en_cycles;
    req_en = 3'b100;
    serve("t4", 3'b100);
    check("t4_no_en", 32'(en_cycles - e0), 32'd0);

    // 5: reset mid-command, rr back to 0
    set_req(1, 1'b0, 0, 0, 639, 479, 12'h222);
    req_en = 3'b010;
    serve("t5a", 3'b010);
    gp_delay = 20;
    set_req(2, 1'b0, 5, 5, 100, 100, 12'h333);
    req_en = 3'b100;
    wait_gp_en("t5_en");
    tick();
    tick();
    rst = 1'b1;
    req_en = 3'b101;
    tick();
    check("t5_en_rst", 32'(gp_en), 32'd0);
    check("t5_grant_rst", 32'(grant), 32'd0);
    check("t5_rf_rst", 32'(req_finish), 32'd0);
    check("t5_tl_rst", 32'(gp_tl_x), 32'd0);
    rst = 1'b0;
    gp_delay = 3;
    for (int j = 0; j < 20 && grant == '0; j++) tick();
    check("t5_first", 32'(grant), 32'd1);
    serve("t5b", 3'b001);
    serve("t5c", 3'b100);

    // 6: owner drops req_en in EXEC, fields move
    gp_delay = 8;
    set_req(0, 1'b0, 10, 20, 30, 40, 12'h555);
    req_en = 3'b001;
    wait_gp_en("t6_en");
    tick();
    req_en = '0;
    set_req(0, 1'b1, 1, 1, 2, 2, 12'hFFF);
    set_req(1, 1'b1, 3, 3, 4, 4, 12'hEEE);
    for (k = 0; k < 50; k++) begin
      check("t6_hold",
            {gp_opcode, gp_tl_x, gp_br_y, gp_arg},
            {1'b0, 10'd10, 9'd40, 12'h555});
      if (gp_finish) break;
      tick();
    end
    check("t6_fin", 32'(gp_finish), 32'd1);
    tick();
    check("t6_rf", 32'(req_finish), 32'd1);
    check("t6_grant_d", 32'(grant), 32'd1);
    tick();
    check("t6_done_1", 32'(grant), 32'd0);
    check("t6_rf_clr", 32'(req_finish), 32'd0);
    check("t6_en_off", 32'(gp_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
